// File: rtl/seq_shift_add_multiplier_16.sv
// Sequential 16x16 unsigned shift-add multiplier.
// A single ripple-carry adder is the only arithmetic resource.
// One shift-add iteration runs per clock, 16 in total.
// A start/busy/done handshake frames each operation.

// 16-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder_16 (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic w_c;

  // Walk the carry from bit 0 upward through each full-adder cell.
  always_comb begin
    sum  = '0;
    w_c  = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = in1[i] ^ in2[i] ^ w_c;
      w_c    = (in1[i] & in2[i]) | (w_c & (in1[i] ^ in2[i]));
    end
    cout = w_c;
  end

endmodule

module seq_shift_add_multiplier_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  output logic [31:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [15:0] r_m;
  logic [15:0] r_a;
  logic [15:0] r_q;
  logic [3:0]  r_cnt;
  logic [31:0] r_product;

  logic [15:0] w_sum;
  logic        w_cout;
  logic [16:0] w_partial;
  logic [31:0] w_shifted;
  logic        w_accept;
  logic        w_lastIter;

  ripple_carry_adder_16 u_adder (
    .in1  (r_a),
    .in2  (r_m),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Conditionally add M into A (keeping the carry), then shift {C,A,Q} right by one.
  always_comb begin
    w_partial = {1'b0, r_a};
    if (r_q[0]) begin
      w_partial = {w_cout, w_sum};
    end
    w_shifted  = {w_partial, r_q[15:1]};
    w_lastIter = (r_state == BUSY) && (r_cnt == 4'd15);
  end

  // The closing edge of the DONE cycle is also a sampling point for start, so a
  // held start restarts on a 17-cycle cadence; start is otherwise ignored in BUSY/DONE.
  always_comb begin
    w_accept    = 1'b0;
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd15) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = BUSY;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m   <= in1;
      r_a   <= '0;
      r_q   <= in2;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_a   <= w_shifted[31:16];
      r_q   <= w_shifted[15:0];
      r_cnt <= r_cnt + 4'd1;
      if (w_lastIter) begin
        r_product <= w_shifted;
      end
    end
  end

  // Handshake outputs decode registered state only.
  always_comb begin
    busy    = (r_state == BUSY);
    done    = (r_state == DONE);
    product = r_product;
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier_16.sv
// Self-checking bench for seq_shift_add_multiplier_16.
// Expected products are queued with their due cycle when stimulus is driven.
// A monitor pops and compares them whenever done is seen.

module tb_seq_shift_add_multiplier_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int errors;
  int checks;
  int cyc;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    int          due;
  } exp_t;

  vec_t vecs[8];
  exp_t expQ[$];

  seq_shift_add_multiplier_16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so due cycles can be compared.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      checkOutput("busy low during done", {31'b0, busy}, 32'h0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", 32'h1, 32'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("product", product, e.p);
        checkOutput("done cycle", cyc, e.due);
      end
    end
  end

  // Start one operation, then watch busy until done appears (bounded).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
    int  busyCnt;
    bit  seen;
    exp_t e;
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    e.p   = p;
    e.due = cyc + 17;
    expQ.push_back(e);
    busyCnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      in1   = 16'hBEEF;
      in2   = 16'hCAFE;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busyCnt++;
    end
    checkOutput("done seen", {31'b0, seen}, 32'h1);
    checkOutput("busy cycles", busyCnt, 16);
  endtask

  initial begin
    exp_t e;
    int   busyCnt;
    int   t0;
    logic [15:0] ra;
    logic [15:0] rb;

    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    in1    = '0;
    in2    = '0;

    vecs[0] = '{16'h0001, 16'h0000, 32'h00000000};
    vecs[1] = '{16'h000A, 16'h0003, 32'h0000001E};
    vecs[2] = '{16'hD000, 16'hA000, 32'h82000000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[4] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[5] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[7] = '{16'h8000, 16'h8000, 32'h40000000};

    repeat (2) @(negedge clk);
    checkOutput("reset product", product, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p);
    end

    $display("[TB] ignored start and operand changes");
    @(negedge clk);
    in1   = 16'h000A;
    in2   = 16'h0003;
    start = 1'b1;
    e.p   = 32'h0000001E;
    e.due = cyc + 17;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    busyCnt = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
    end
    start = 1'b1;
    in1   = 16'h0007;
    in2   = 16'h0007;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      in1 = in1 + 16'h0101;
      in2 = in2 ^ 16'h00FF;
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
    end
    checkOutput("ignored-start busy cycles", busyCnt, 16);
    checkOutput("ignored-start queue empty", expQ.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("no second op busy", {31'b0, busy}, 32'h0);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    in1   = 16'hFFFF;
    in2   = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("mid-op busy before reset", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", {31'b0, busy}, 32'h0);
    checkOutput("abort done", {31'b0, done}, 32'h0);
    checkOutput("abort product", product, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort idle product", product, 32'h0);
    applyStimulus(16'h0003, 16'h0005, 32'h0000000F);

    $display("[TB] back-to-back with start held");
    @(negedge clk);
    in1   = 16'h1234;
    in2   = 16'h5678;
    start = 1'b1;
    t0    = cyc;
    for (int k = 0; k < 3; k++) begin
      e.p   = 32'h06260060;
      e.due = t0 + 17 + 17 * k;
      expQ.push_back(e);
    end
    repeat (40) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && expQ.size() > 0; i++) @(negedge clk);
    checkOutput("back-to-back drained", expQ.size(), 0);
    repeat (20) @(negedge clk);

    $display("[TB] random operands");
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i == 0) ra = 16'hFFFF;
      applyStimulus(ra, rb, 32'(ra) * 32'(rb));
    end

    for (int i = 0; i < 100 && expQ.size() > 0; i++) @(negedge clk);
    checkOutput("final queue drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
